// File: rtl/cnt_seq_if.sv
// -----------------------------------------------------------------------------
// cnt_seq_if
//   Bundles the observed counter bus and the health outputs of the sequence
//   checker.
//   master : the side that presents samples (en, cnt_in, clr) and watches the
//            health flags.
//   slave  : the checker itself.
//   Signals:
//     en          sample valid strobe
//     cnt_in      observed count value (WIDTH bits)
//     clr         clear request for err_sticky / err_count
//     locked      checker is locked onto the sequence
//     err_pulse   one-cycle pulse per sequence break
//     err_sticky  latched error flag
//     err_count   saturating error tally (ERR_CNT_W bits)
// -----------------------------------------------------------------------------
interface cnt_seq_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic [WIDTH-1:0]     cnt_in;
    logic                 clr;
    logic                 locked;
    logic                 err_pulse;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output en,
        output cnt_in,
        output clr,
        input  locked,
        input  err_pulse,
        input  err_sticky,
        input  err_count
    );

    modport slave (
        input  en,
        input  cnt_in,
        input  clr,
        output locked,
        output err_pulse,
        output err_sticky,
        output err_count
    );
endinterface

// File: rtl/cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// cnt_seq_checker
//   Monitors a free-running counter bus. Every valid sample must be the
//   previous sample plus one, wrapping MAX_VAL -> 0. The checker hunts for a
//   starting value, needs SYNC_LEN consecutive good steps to lock, and while
//   locked reports every break with a pulse, a sticky flag and a saturating
//   tally.
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   asynchronous reset, active-high
//     bus   slave modport of cnt_seq_if:
//             en, cnt_in, clr            (inputs)
//             locked, err_pulse,
//             err_sticky, err_count      (registered outputs)
// -----------------------------------------------------------------------------
module cnt_seq_checker #(
    parameter int WIDTH     = 4,
    parameter int MAX_VAL   = 15,
    parameter int SYNC_LEN  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    cnt_seq_if.slave  bus
);
    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam int                   MATCH_W = $clog2(SYNC_LEN + 1);
    localparam logic [WIDTH-1:0]     MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [MATCH_W-1:0]   SYNC_W  = MATCH_W'(SYNC_LEN);
    localparam logic [ERR_CNT_W-1:0] CNT_ALL = {ERR_CNT_W{1'b1}};

    logic [1:0]           state_reg, state_next;
    logic [WIDTH-1:0]     prev_reg, prev_next;
    logic [MATCH_W-1:0]   match_reg, match_next;
    logic                 locked_reg, locked_next;
    logic                 err_pulse_reg;
    logic                 err_sticky_reg, err_sticky_next;
    logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

    logic [WIDTH-1:0]     expected_val;
    logic                 in_range;
    logic                 hit;
    logic                 err_event;
    logic [MATCH_W-1:0]   match_inc;
    logic [ERR_CNT_W-1:0] err_base;

    // Next value the upstream counter should present. A prev beyond MAX_VAL
    // simply increments (truncated); such an expectation can never be met
    // because out-of-range samples never match.
    assign expected_val = (prev_reg == MAX_W) ? '0 : prev_reg + 1'b1;
    assign in_range     = (bus.cnt_in <= MAX_W);
    assign hit          = in_range && (bus.cnt_in == expected_val);
    assign match_inc    = match_reg + 1'b1;

    // Only a mismatch while locked counts as a sequence break.
    assign err_event    = bus.en && (state_reg == ST_LOCK) && !hit;

    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        match_next = match_reg;

        if (bus.en) begin
            // Every valid sample becomes the new reference, including the
            // offending one, so the checker resyncs on whatever arrived.
            prev_next = bus.cnt_in;
            case (state_reg)
                ST_HUNT: begin
                    match_next = '0;
                    state_next = ST_SYNC;
                end
                ST_SYNC: begin
                    if (hit) begin
                        match_next = match_inc;
                        if (match_inc >= SYNC_W) begin
                            state_next = ST_LOCK;
                        end
                    end else begin
                        match_next = '0;
                    end
                end
                ST_LOCK: begin
                    if (!hit) begin
                        match_next = '0;
                        state_next = ST_SYNC;
                    end
                end
                default: begin
                    match_next = '0;
                    state_next = ST_HUNT;
                end
            endcase
        end
    end

    assign locked_next = (state_next == ST_LOCK);

    // A clear and an error in the same cycle: the clear empties the tally
    // first and the error is then counted on top of it.
    always_comb begin
        err_base        = bus.clr ? '0 : err_count_reg;
        err_count_next  = err_base;
        err_sticky_next = bus.clr ? 1'b0 : err_sticky_reg;
        if (err_event) begin
            err_sticky_next = 1'b1;
            if (err_base != CNT_ALL) begin
                err_count_next = err_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_HUNT;
            prev_reg       <= '0;
            match_reg      <= '0;
            locked_reg     <= 1'b0;
            err_pulse_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            prev_reg       <= prev_next;
            match_reg      <= match_next;
            locked_reg     <= locked_next;
            err_pulse_reg  <= err_event;
            err_sticky_reg <= err_sticky_next;
            err_count_reg  <= err_count_next;
        end
    end

    assign bus.locked     = locked_reg;
    assign bus.err_pulse  = err_pulse_reg;
    assign bus.err_sticky = err_sticky_reg;
    assign bus.err_count  = err_count_reg;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_cnt_seq_checker
//   Two checker instances share clock and reset:
//     dut_a : WIDTH=4, MAX_VAL=15, SYNC_LEN=2, ERR_CNT_W=8
//     dut_b : WIDTH=4, MAX_VAL=9,  SYNC_LEN=2, ERR_CNT_W=2
//   Each sample is driven after a falling edge together with the outputs it
//   should produce; those expectations queue up and are popped and compared
//   just after the rising edge that takes the sample.
// -----------------------------------------------------------------------------
module tb_cnt_seq_checker;
    logic clk;
    logic rst;

    cnt_seq_if #(.WIDTH(4), .ERR_CNT_W(8)) bus_a ();
    cnt_seq_if #(.WIDTH(4), .ERR_CNT_W(2)) bus_b ();

    cnt_seq_checker #(.WIDTH(4), .MAX_VAL(15), .SYNC_LEN(2), .ERR_CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    cnt_seq_checker #(.WIDTH(4), .MAX_VAL(9), .SYNC_LEN(2), .ERR_CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int    dut;
        int    locked;
        int    pulse;
        int    sticky;
        int    count;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs == expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input int d, input string tag, input int xl,
                                 input int xp, input int xs, input int xc);
        if (d == 0) begin
            chk({tag, ".locked"},  int'(bus_a.locked),     xl);
            chk({tag, ".pulse"},   int'(bus_a.err_pulse),  xp);
            chk({tag, ".sticky"},  int'(bus_a.err_sticky), xs);
            chk({tag, ".count"},   int'(bus_a.err_count),  xc);
        end else begin
            chk({tag, ".locked"},  int'(bus_b.locked),     xl);
            chk({tag, ".pulse"},   int'(bus_b.err_pulse),  xp);
            chk({tag, ".sticky"},  int'(bus_b.err_sticky), xs);
            chk({tag, ".count"},   int'(bus_b.err_count),  xc);
        end
    endtask

    // One sample on DUT d; the other DUT idles with en=0.
    task automatic step(input int d, input logic e, input int v, input logic c,
                        input int xl, input int xp, input int xs, input int xc,
                        input string tag);
        exp_t x;
        exp_t got;
        @(negedge clk);
        bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.cnt_in = '0;
        bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.cnt_in = '0;
        if (d == 0) begin
            bus_a.en = e; bus_a.clr = c; bus_a.cnt_in = 4'(v);
        end else begin
            bus_b.en = e; bus_b.clr = c; bus_b.cnt_in = 4'(v);
        end
        x.dut = d; x.locked = xl; x.pulse = xp; x.sticky = xs; x.count = xc; x.tag = tag;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 0, 1);
        end else begin
            got = exp_q.pop_front();
            check_outputs(got.dut, $sformatf("%s[v=%0d]", got.tag, v),
                          got.locked, got.pulse, got.sticky, got.count);
            $display("sample dut%0d %s en=%0b v=%0d clr=%0b", d, tag, e, v, c);
        end
    endtask

    initial begin
        int p;
        int b;
        int xc;

        bus_a.en = 1'b0; bus_a.clr = 1'b0; bus_a.cnt_in = '0;
        bus_b.en = 1'b0; bus_b.clr = 1'b0; bus_b.cnt_in = '0;
        rst = 1'b1;
        #1;
        check_outputs(0, "reset_a", 0, 0, 0, 0);
        check_outputs(1, "reset_b", 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Clean run through the 15 -> 0 wrap: lock after the third sample.
        for (int i = 0; i < 19; i++) begin
            step(0, 1'b1, i % 16, 1'b0, (i >= 2) ? 1 : 0, 0, 0, 0, "run");
        end

        // Break while locked: 5 instead of 8, relock after 6,7.
        for (int v = 3; v <= 7; v++) step(0, 1'b1, v, 1'b0, 1, 0, 0, 0, "pre_brk");
        step(0, 1'b1, 5, 1'b0, 0, 1, 1, 1, "brk");
        step(0, 1'b1, 6, 1'b0, 0, 0, 1, 1, "brk_r1");
        step(0, 1'b1, 7, 1'b0, 1, 0, 1, 1, "brk_r2");

        // Upstream reset 7,8,0,1,2 then an en gap.
        step(0, 1'b1, 8, 1'b0, 1, 0, 1, 1, "ur_8");
        step(0, 1'b1, 0, 1'b0, 0, 1, 1, 2, "ur_0");
        step(0, 1'b1, 1, 1'b0, 0, 0, 1, 2, "ur_1");
        step(0, 1'b1, 2, 1'b0, 1, 0, 1, 2, "ur_2");
        for (int i = 0; i < 3; i++) step(0, 1'b0, 9, 1'b0, 1, 0, 1, 2, "en_gap");
        step(0, 1'b1, 3, 1'b0, 1, 0, 1, 2, "gap_3");
        step(0, 1'b1, 4, 1'b0, 1, 0, 1, 2, "gap_4");

        // MAX_VAL=9 instance: 9 -> 0 is legal, 10 is an error.
        step(1, 1'b1, 7,  1'b0, 0, 0, 0, 0, "m9_7");
        step(1, 1'b1, 8,  1'b0, 0, 0, 0, 0, "m9_8");
        step(1, 1'b1, 9,  1'b0, 1, 0, 0, 0, "m9_9");
        step(1, 1'b1, 0,  1'b0, 1, 0, 0, 0, "m9_wrap");
        step(1, 1'b1, 10, 1'b0, 0, 1, 1, 1, "m9_oor");
        step(1, 1'b1, 11, 1'b0, 0, 0, 1, 1, "m9_oor2");
        step(1, 1'b1, 0,  1'b0, 0, 0, 1, 1, "m9_re0");
        step(1, 1'b1, 1,  1'b0, 0, 0, 1, 1, "m9_re1");
        step(1, 1'b1, 2,  1'b0, 1, 0, 1, 1, "m9_re2");

        // Clear alone, then saturation of the 2-bit tally.
        step(1, 1'b1, 3, 1'b1, 1, 0, 0, 0, "clr_alone");
        p = 3;
        for (int k = 0; k < 5; k++) begin
            xc = (k + 1 > 3) ? 3 : k + 1;
            b  = (p + 5) % 10;
            step(1, 1'b1, b,            1'b0, 0, 1, 1, xc, "sat_err");
            step(1, 1'b1, (b + 1) % 10, 1'b0, 0, 0, 1, xc, "sat_r1");
            step(1, 1'b1, (b + 2) % 10, 1'b0, 1, 0, 1, xc, "sat_r2");
            p = (b + 2) % 10;
        end
        b = (p + 5) % 10;
        step(1, 1'b1, b,            1'b1, 0, 1, 1, 1, "clr_vs_err");
        step(1, 1'b1, (b + 1) % 10, 1'b0, 0, 0, 1, 1, "after_cve");

        // Asynchronous reset mid-cycle while dut_a is locked with err_count=2.
        step(0, 1'b1, 5, 1'b0, 1, 0, 1, 2, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check_outputs(0, "async_rst", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(0, 1'b1, 5, 1'b0, 0, 0, 0, 0, "post_rst_5");
        step(0, 1'b1, 6, 1'b0, 0, 0, 0, 0, "post_rst_6");
        step(0, 1'b1, 7, 1'b0, 1, 0, 0, 0, "post_rst_7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
